// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
//   state_e : sequencer states (IDLE, RMW)
//   port_e  : requester identities (CPU load/store = 0, DMA/loader = 1)
//   BE_FULL : byte-enable pattern that marks a full-word store
package ram_arb_pkg;

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_e;

  typedef enum logic {PORT_CPU = 1'b0, PORT_DMA = 1'b1} port_e;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports plus the single RAM port.
//   Requester side : req_i, we_i, addr_i, wdata_i, be_i -> gnt_o, rvalid_o, rdata_o
//   RAM side       : ram_we_o, ram_a_o, ram_wd_o <- ram_rd_i
// slave  : the arbiter's view (drives grants, responses and the RAM port)
// master : the requesters' and RAM's view
interface ram_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BE_W  = WIDTH / 8
);
  logic [1:0]                  req_i;
  logic [1:0]                  we_i;
  logic [1:0][WIDTH-1:0]       addr_i;
  logic [1:0][WIDTH-1:0]       wdata_i;
  logic [1:0][BE_W-1:0]        be_i;
  logic [1:0]                  gnt_o;
  logic [1:0]                  rvalid_o;
  logic [WIDTH-1:0]            rdata_o;
  logic                        ram_we_o;
  logic [WIDTH-1:0]            ram_a_o;
  logic [WIDTH-1:0]            ram_wd_o;
  logic [WIDTH-1:0]            ram_rd_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, ram_rd_i,
    output gnt_o, rvalid_o, rdata_o, ram_we_o, ram_a_o, ram_wd_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, ram_rd_i,
    input  gnt_o, rvalid_o, rdata_o, ram_we_o, ram_a_o, ram_wd_o
  );
endinterface

// File: rtl/ram_byte_merge.sv
// Combinational byte-lane merge for read-modify-write stores.
//   old_word : current RAM contents
//   new_word : store data
//   be       : byte enables, bit n selects lane [8n+7:8n] from new_word
//   merged   : resulting word
module ram_byte_merge #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BE_W  = WIDTH / 8
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  input  logic [BE_W-1:0]  be,
  output logic [WIDTH-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int n = 0; n < int'(BE_W); n++) begin
      if (be[n]) merged[8*n +: 8] = new_word[8*n +: 8];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and sequencer for the data RAM.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   bus           : requester ports 0 (CPU) / 1 (DMA) and the single RAM port
// Reads and full-word writes complete in the grant cycle with a registered response
// one cycle later; partial writes read-merge in the grant cycle and write in a
// following RMW cycle, during which no new grant is issued.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BE_W  = WIDTH / 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ram_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  port_e            last_q, rmw_port_q;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rmw_addr_q, rmw_data_q;

  logic             win;
  logic             accept;
  logic             win_we;
  logic [WIDTH-1:0] win_addr, win_wdata, merged;
  logic [BE_W-1:0]  win_be;
  logic             full_wr, part_wr;

  // Under contention the port that did not win last time goes first.
  assign win       = (bus.req_i == 2'b11) ? ~last_q : bus.req_i[1];
  assign accept    = (state_q == IDLE) && (bus.req_i != 2'b00);
  assign win_we    = bus.we_i[win];
  assign win_addr  = {bus.addr_i[win][WIDTH-1:2], 2'b00};
  assign win_wdata = bus.wdata_i[win];
  assign win_be    = bus.be_i[win];
  assign full_wr   = win_we && (win_be == BE_FULL);
  assign part_wr   = win_we && (win_be != '0) && (win_be != BE_FULL);

  ram_byte_merge #(
    .WIDTH (WIDTH),
    .BE_W  (BE_W)
  ) u_merge (
    .old_word (bus.ram_rd_i),
    .new_word (win_wdata),
    .be       (win_be),
    .merged   (merged)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && part_wr) state_d = RMW;
      RMW:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: grant and RAM port.
  always_comb begin
    bus.gnt_o    = 2'b00;
    bus.ram_we_o = 1'b0;
    bus.ram_a_o  = '0;
    bus.ram_wd_o = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bus.gnt_o[win] = 1'b1;
          bus.ram_a_o    = win_addr;
          if (full_wr) begin
            bus.ram_we_o = 1'b1;
            bus.ram_wd_o = win_wdata;
          end
        end
      end
      RMW: begin
        bus.ram_we_o = 1'b1;
        bus.ram_a_o  = rmw_addr_q;
        bus.ram_wd_o = rmw_data_q;
      end
      default: ;
    endcase
  end

  // Partial writes respond after their RMW cycle rather than after the grant.
  always_comb begin
    rvalid_d = 2'b00;
    if (accept && !part_wr) rvalid_d[win] = 1'b1;
    if (state_q == RMW)     rvalid_d[rmw_port_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= PORT_DMA;
      rmw_port_q <= PORT_CPU;
      rvalid_q   <= 2'b00;
      rdata_q    <= '0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (accept) begin
        last_q <= port_e'(win);
        if (!win_we) rdata_q <= bus.ram_rd_i;
        if (part_wr) begin
          rmw_port_q <= port_e'(win);
          rmw_addr_q <= win_addr;
          rmw_data_q <= merged;
        end
      end
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small word-array RAM model.
module tb_ram_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [31:0] mem [0:15];
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_val;

  ram_arbiter_if #(.WIDTH(32)) bus ();

  ram_arbiter #(.WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, full-word write on the rising edge.
  assign bus.ram_rd_i = mem[bus.ram_a_o[5:2]];
  always @(posedge clk) begin
    if (ld_en)             mem[ld_idx] <= ld_val;
    else if (bus.ram_we_o) mem[bus.ram_a_o[5:2]] <= bus.ram_wd_o;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [3:0] idx, input logic [31:0] val);
    ld_idx = idx;
    ld_val = val;
    ld_en  = 1'b1;
    @(posedge clk); #1;
    ld_en  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  logic [1:0]  exp_gnt [4];
  logic [1:0]  exp_rv  [4];
  logic [31:0] exp_rd  [4];

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_val = '0;
    bus.req_i = '0;
    bus.we_i = '0;
    bus.addr_i = '0;
    bus.wdata_i = '0;
    bus.be_i = '0;

    load(4'd0, 32'hDEADBEEF);
    load(4'd1, 32'h0);
    load(4'd2, 32'h22222222);
    load(4'd3, 32'h11223344);

    // Reset state
    check_eq("rst_gnt", {30'd0, bus.gnt_o}, 32'd0);
    check_eq("rst_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
    check_eq("rst_rdata", bus.rdata_o, 32'd0);
    check_eq("rst_ram_we", {31'd0, bus.ram_we_o}, 32'd0);
    check_eq("rst_ram_a", bus.ram_a_o, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Single read from port 0
    bus.req_i = 2'b01;
    bus.addr_i[0] = 32'h10000;
    @(negedge clk);
    check_eq("rd0_gnt", {30'd0, bus.gnt_o}, 32'd1);
    check_eq("rd0_ram_a", bus.ram_a_o, 32'h10000);
    check_eq("rd0_ram_we", {31'd0, bus.ram_we_o}, 32'd0);
    next_cycle();
    bus.req_i = 2'b00;
    @(negedge clk);
    check_eq("rd0_rvalid", {30'd0, bus.rvalid_o}, 32'd1);
    check_eq("rd0_rdata", bus.rdata_o, 32'hDEADBEEF);
    check_eq("rd0_gnt_idle", {30'd0, bus.gnt_o}, 32'd0);

    // Fresh reset so port 0 wins the first contest
    next_cycle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();

    // Contention: both read every cycle
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01};
    exp_rd  = '{32'h0, 32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF};
    bus.req_i = 2'b11;
    bus.we_i = 2'b00;
    bus.addr_i[0] = 32'h10000;
    bus.addr_i[1] = 32'h10008;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("cont_gnt%0d", i), {30'd0, bus.gnt_o}, {30'd0, exp_gnt[i]});
      check_eq($sformatf("cont_rv%0d", i), {30'd0, bus.rvalid_o}, {30'd0, exp_rv[i]});
      check_eq($sformatf("cont_rd%0d", i), bus.rdata_o, exp_rd[i]);
      next_cycle();
    end
    bus.req_i = 2'b00;
    @(negedge clk);
    check_eq("cont_rv_last", {30'd0, bus.rvalid_o}, 32'd2);
    check_eq("cont_rd_last", bus.rdata_o, 32'h22222222);

    // Partial write from port 1, port 0 read arrives during RMW
    next_cycle();
    bus.req_i = 2'b10;
    bus.we_i = 2'b10;
    bus.addr_i[1] = 32'h1000C;
    bus.wdata_i[1] = 32'hAABBCCDD;
    bus.be_i[1] = 4'b0101;
    @(negedge clk);
    check_eq("pw_gnt", {30'd0, bus.gnt_o}, 32'd2);
    check_eq("pw_grant_no_we", {31'd0, bus.ram_we_o}, 32'd0);
    next_cycle();
    bus.req_i = 2'b01;
    bus.we_i = 2'b00;
    bus.addr_i[0] = 32'h1000C;
    @(negedge clk);
    check_eq("rmw_gnt", {30'd0, bus.gnt_o}, 32'd0);
    check_eq("rmw_we", {31'd0, bus.ram_we_o}, 32'd1);
    check_eq("rmw_a", bus.ram_a_o, 32'h1000C);
    check_eq("rmw_wd", bus.ram_wd_o, 32'h11BB33DD);
    check_eq("rmw_rvalid", {30'd0, bus.rvalid_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("post_rmw_gnt", {30'd0, bus.gnt_o}, 32'd1);
    check_eq("pw_rvalid", {30'd0, bus.rvalid_o}, 32'd2);
    check_eq("pw_rdata_held", bus.rdata_o, 32'h22222222);
    next_cycle();
    bus.req_i = 2'b00;
    @(negedge clk);
    check_eq("rd_after_rmw_rv", {30'd0, bus.rvalid_o}, 32'd1);
    check_eq("rd_after_rmw", bus.rdata_o, 32'h11BB33DD);

    // Full write then back-to-back read of the same word
    next_cycle();
    bus.req_i = 2'b01;
    bus.we_i = 2'b01;
    bus.addr_i[0] = 32'h10004;
    bus.wdata_i[0] = 32'hCAFEF00D;
    bus.be_i[0] = 4'hF;
    @(negedge clk);
    check_eq("fw_gnt", {30'd0, bus.gnt_o}, 32'd1);
    check_eq("fw_we", {31'd0, bus.ram_we_o}, 32'd1);
    check_eq("fw_wd", bus.ram_wd_o, 32'hCAFEF00D);
    next_cycle();
    bus.we_i = 2'b00;
    @(negedge clk);
    check_eq("fw_rd_gnt", {30'd0, bus.gnt_o}, 32'd1);
    check_eq("fw_rvalid", {30'd0, bus.rvalid_o}, 32'd1);
    check_eq("fw_rdata_held", bus.rdata_o, 32'h11BB33DD);
    next_cycle();
    bus.req_i = 2'b00;
    @(negedge clk);
    check_eq("raw_rvalid", {30'd0, bus.rvalid_o}, 32'd1);
    check_eq("raw_rdata", bus.rdata_o, 32'hCAFEF00D);

    // be=0 write, then misaligned read
    next_cycle();
    bus.req_i = 2'b10;
    bus.we_i = 2'b10;
    bus.addr_i[1] = 32'h10000;
    bus.wdata_i[1] = 32'h0;
    bus.be_i[1] = 4'h0;
    @(negedge clk);
    check_eq("be0_gnt", {30'd0, bus.gnt_o}, 32'd2);
    check_eq("be0_no_we", {31'd0, bus.ram_we_o}, 32'd0);
    next_cycle();
    bus.we_i = 2'b00;
    bus.addr_i[1] = 32'h10006;
    @(negedge clk);
    check_eq("mis_ram_a", bus.ram_a_o, 32'h10004);
    check_eq("be0_rvalid", {30'd0, bus.rvalid_o}, 32'd2);
    next_cycle();
    bus.req_i = 2'b00;
    @(negedge clk);
    check_eq("mis_rdata", bus.rdata_o, 32'hCAFEF00D);
    check_eq("be0_mem_kept", mem[0], 32'hDEADBEEF);

    // Reset asserted during RMW
    next_cycle();
    bus.req_i = 2'b01;
    bus.we_i = 2'b01;
    bus.addr_i[0] = 32'h1000C;
    bus.wdata_i[0] = 32'h000000EE;
    bus.be_i[0] = 4'b0001;
    @(negedge clk);
    check_eq("rr_gnt", {30'd0, bus.gnt_o}, 32'd1);
    next_cycle();
    bus.req_i = 2'b00;
    bus.we_i = 2'b00;
    @(negedge clk);
    check_eq("rr_in_rmw", {31'd0, bus.ram_we_o}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rr_we_off", {31'd0, bus.ram_we_o}, 32'd0);
    check_eq("rr_a_off", bus.ram_a_o, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rr_rvalid0", {30'd0, bus.rvalid_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_eq("rr_rvalid1", {30'd0, bus.rvalid_o}, 32'd0);
    check_eq("rr_mem_kept", mem[3], 32'h11BB33DD);
    next_cycle();
    bus.req_i = 2'b01;
    bus.addr_i[0] = 32'h1000C;
    @(negedge clk);
    check_eq("rr_idle_gnt", {30'd0, bus.gnt_o}, 32'd1);
    next_cycle();
    bus.req_i = 2'b00;
    @(negedge clk);
    check_eq("rr_idle_rdata", bus.rdata_o, 32'h11BB33DD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the data RAM (32-bit byte-addressed array, combinational read, full-word synchronous write). It shares the single RAM port between the CPU load/store path (port 0) and the DMA/loader path (port 1) using round-robin arbitration. Byte-enabled stores are converted into read-modify-write sequences, and every accepted request receives a registered response.

## Interface
- `WIDTH`, default 32: address and data width.
- `BE_W`, default 4: byte-enable width. Fixed at `WIDTH/8`.

Ports:
- `clk_i`, input, 1: clock, rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `req_i`, input, [1:0]: per-port request. Must be held until granted.
- `we_i`, input, [1:0]: per-port write (1) / read (0).
- `addr_i`, input, 2×WIDTH: per-port byte address. Bits [1:0] are ignored (word-aligned).
- `wdata_i`, input, 2×WIDTH: per-port write data.
- `be_i`, input, 2×BE_W: per-port byte enables. Bit n selects byte lane n, i.e. bits [8n+7:8n].
- `gnt_o`, output, [1:0]: one-hot grant. Combinational, same cycle as acceptance.
- `rvalid_o`, output, [1:0]: one-cycle response pulse per port.
- `rdata_o`, output, WIDTH: read data. Valid when any `rvalid_o` bit is high.
- `ram_we_o`, output, 1: RAM write enable.
- `ram_a_o`, output, WIDTH: RAM address, always `{addr[WIDTH-1:2],2'b00}`.
- `ram_wd_o`, output, WIDTH: RAM write data.
- `ram_rd_i`, input, WIDTH: RAM combinational read data.

## Operation
- FSM states are IDLE and RMW.
- **IDLE**
  - No request: `gnt_o=0`, `ram_we_o=0`, `ram_a_o=0`.
  - Arbitration: one requester wins by request. Two requesters are resolved by round-robin: the port not granted most recently wins. `last_q` updates on every grant.
  - Read: `ram_a_o` = granted address. `ram_rd_i` is registered into `rdata_o`.
  - Write with `be=4'hF`: `ram_we_o=1`, `ram_wd_o=wdata` in the grant cycle.
  - Write with `be=0`: no RAM write; the request is still acknowledged.
  - Partial write (`be` neither 0 nor F):
    - In the grant cycle: latch the address and the merged word into registers. Lanes with `be=1` take `wdata`; the remaining lanes take `ram_rd_i`.
    - Next state is RMW.
- **RMW**
  - `gnt_o=0`; new requests wait.
  - Drive `ram_we_o=1` with the latched address and merged word.
  - Return to IDLE.
- **Responses**
  - `rvalid_o[p]` pulses in the cycle after the grant (read, full write, `be=0`), or in the cycle after the RMW write cycle (partial write).
  - Write responses leave `rdata_o` unchanged.
- `rdata_o` holds its last value between responses.

## Timing
- Reset values: state IDLE, `last_q=1` (port 0 wins the first contest), `rvalid_o=0`, `rdata_o=0`, `ram_we_o=0`.
- Latency:
  - Read: 1 cycle from grant to `rvalid_o`.
  - Full write: 1 cycle.
  - Partial write: 2 cycles.
- Throughput: one read or full write per cycle. A grant may coincide with the previous request's `rvalid_o`.
- Partial write blocks both ports for exactly one extra cycle.
- Read in the cycle after a write to the same word returns the new data, because the RAM write commits at the edge.
- Both ports requesting every cycle: grants strictly alternate.
- Reset asserted during RMW: the write is abandoned, no `ram_we_o` is issued and no `rvalid_o` is produced. Reset takes effect immediately, asynchronously.
- `req_i` dropped before grant: no effect and no response.

## Structure
- Package `ram_arb_pkg` holds:
  - `state_e` enum {IDLE, RMW}.
  - `BE_FULL = 4'hF` constant.
  - `port_e` enum {PORT_CPU=0, PORT_DMA=1}.
- Sub-module `ram_byte_merge`: combinational lane merge, (old, new, be) -> word.
- Top level contains the FSM, round-robin pointer, and response registers.

## Test plan
- **Reset and idle:** after reset, all outputs are 0. Port 0 read of 0x10000 with RAM word 0xDEADBEEF -> `gnt_o=01` the same cycle; `rvalid_o=01` and `rdata_o=0xDEADBEEF` the next cycle.
- **Contention:** both ports request reads continuously for 4 cycles -> `gnt_o` sequence 01, 10, 01, 10, with `rvalid_o` following one cycle later.
- **Partial write:** RAM word 0x11223344, port 1 writes 0xAABBCCDD with `be=4'b0101` -> RMW writes 0x11BB33DD. `rvalid_o=10` two cycles after grant. A port 0 request during RMW is granted only in the following cycle.
- **Full write then read:** write 0xCAFEF00D to 0x10004 with `be=F`, then read the same address in the next cycle -> `rdata_o=0xCAFEF00D`. Throughput is 1 per cycle.
- **`be=0` and misaligned address:** write with `be=0` -> no `ram_we_o`, `rvalid_o` still pulses. Read at 0x10006 -> `ram_a_o=0x10004`.
- **Reset during RMW:** assert `rst_ni=0` in the RMW cycle -> `ram_we_o=0` immediately, no `rvalid_o`, state IDLE.
